// File: rtl/mult_pkg.sv
// Shared types and width helpers for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    // Operating modes of mult_sign_fix.
    localparam logic MODE_ABS = 1'b0;
    localparam logic MODE_NEG = 1'b1;

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/mult_sign_fix.sv
// Combinational sign helper: magnitude of a WIDTH-bit signed value, or
// conditional negation of a 2*WIDTH-bit value, selected by mode.
module mult_sign_fix
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 mode,
    input  logic                 en,
    input  logic [2*WIDTH-1:0]   din,
    output logic [2*WIDTH-1:0]   dout
);

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        dout = din;
        if (mode == MODE_ABS) begin
            dout = {{WIDTH{1'b0}}, din[WIDTH-1:0]};
            // The most-negative value maps to 2^(WIDTH-1), still exact unsigned.
            if (en && din[WIDTH-1]) begin
                dout[WIDTH-1:0] = -din[WIDTH-1:0];
            end
        end else if (en) begin
            dout = -din;
        end
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-add WIDTH x WIDTH multiplier, unsigned or signed, with
// valid/ready handshakes on operands and product.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            inp1,
    input  logic [WIDTH-1:0]            inp2,
    input  logic                        is_signed,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [prod_width(WIDTH)-1:0] product,
    output logic                        busy
);

    localparam int PW = prod_width(WIDTH);
    localparam int CW = cnt_width(WIDTH);

    state_e            state;
    logic [PW:0]       pair;
    logic [WIDTH-1:0]  mcand;
    logic [CW-1:0]     cnt;
    logic              neg_q;
    logic              signed_q;

    logic [PW-1:0]     mag1_w;
    logic [PW-1:0]     mag2_w;
    logic [PW-1:0]     res_w;
    logic [WIDTH:0]    sum_hi;
    logic [PW:0]       acc_next;

    mult_sign_fix #(.WIDTH(WIDTH)) u_mag1 (
        .mode (MODE_ABS),
        .en   (is_signed),
        .din  ({{WIDTH{1'b0}}, inp1}),
        .dout (mag1_w)
    );

    mult_sign_fix #(.WIDTH(WIDTH)) u_mag2 (
        .mode (MODE_ABS),
        .en   (is_signed),
        .din  ({{WIDTH{1'b0}}, inp2}),
        .dout (mag2_w)
    );

    mult_sign_fix #(.WIDTH(WIDTH)) u_neg (
        .mode (MODE_NEG),
        .en   (signed_q & neg_q),
        .din  (acc_next[PW-1:0]),
        .dout (res_w)
    );

    // Upper accumulator bits hold the partial sum; lower bits the multiplier.
    always_comb begin
        sum_hi = pair[PW:WIDTH];
        if (pair[0]) begin
            sum_hi = pair[PW:WIDTH] + {1'b0, mcand};
        end
        acc_next = {sum_hi, pair[WIDTH-1:0]} >> 1;
    end

    // Magnitude upper halves and the shifted-in top bit are always zero.
    logic unused_bits;
    assign unused_bits = ^{mag1_w[PW-1:WIDTH], acc_next[PW]};

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            product   <= '0;
            pair      <= '0;
            cnt       <= '0;
            mcand     <= '0;
            neg_q     <= 1'b0;
            signed_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        signed_q <= is_signed;
                        neg_q    <= is_signed & (inp1[WIDTH-1] ^ inp2[WIDTH-1]);
                        mcand    <= mag1_w[WIDTH-1:0];
                        pair     <= {1'b0, mag2_w};
                        cnt      <= '0;
                        state    <= CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    pair <= acc_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        product   <= res_w;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier at WIDTH=4 and WIDTH=8.
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        is_signed;
    logic        sel;

    logic        ir4, ov4, bz4;
    logic        ir8, ov8, bz8;
    logic [7:0]  p4;
    logic [15:0] p8;

    logic        ir, ov, bz;
    logic [15:0] prod;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    shift_add_multiplier #(.WIDTH(4)) u4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & ~sel),
        .in_ready  (ir4),
        .inp1      (a[3:0]),
        .inp2      (b[3:0]),
        .is_signed (is_signed),
        .out_valid (ov4),
        .out_ready (out_ready & ~sel),
        .product   (p4),
        .busy      (bz4)
    );

    shift_add_multiplier #(.WIDTH(8)) u8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & sel),
        .in_ready  (ir8),
        .inp1      (a),
        .inp2      (b),
        .is_signed (is_signed),
        .out_valid (ov8),
        .out_ready (out_ready & sel),
        .product   (p8),
        .busy      (bz8)
    );

    assign ir   = sel ? ir8 : ir4;
    assign ov   = sel ? ov8 : ov4;
    assign bz   = sel ? bz8 : bz4;
    assign prod = sel ? p8  : {8'h00, p4};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference product: sign-extend w-bit operands, multiply, keep 2w bits.
    function automatic logic [15:0] model(input int w, input logic [7:0] x,
                                          input logic [7:0] y, input logic s);
        int mask = (1 << w) - 1;
        int ix = int'(x) & mask;
        int iy = int'(y) & mask;
        int p;
        if (s) begin
            if (ix >= (1 << (w - 1))) ix -= (1 << w);
            if (iy >= (1 << (w - 1))) iy -= (1 << w);
        end
        p = ix * iy;
        return 16'(p & ((1 << (2 * w)) - 1));
    endfunction

    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic s);
        @(negedge clk);
        check("in_ready_before_accept", 16'(ir), 16'd1);
        a = x; b = y; is_signed = s; in_valid = 1'b1;
        exp_q.push_back(model(sel ? 8 : 4, x, y, s));
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_after_accept", 16'(bz), 16'd1);
    endtask

    task automatic recv(input bit scramble, input int hold);
        int cyc = 0;
        logic [15:0] got;
        logic [15:0] exp;
        while (!ov && cyc < 40) begin
            if (scramble) begin
                a = 8'($urandom); b = 8'($urandom); is_signed = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        check("latency", 16'(cyc), sel ? 16'd8 : 16'd4);
        got = prod;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check("product", got, exp);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = 8'($urandom); b = 8'($urandom);
            @(negedge clk);
            in_valid = 1'b0;
            check("hold_product", prod, got);
            check("hold_out_valid", 16'(ov), 16'd1);
            check("hold_in_ready", 16'(ir), 16'd0);
            check("hold_busy", 16'(bz), 16'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("taken_out_valid", 16'(ov), 16'd0);
        check("taken_in_ready", 16'(ir), 16'd1);
        check("taken_busy", 16'(bz), 16'd0);
        check("product_kept", prod, got);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; is_signed = 1'b0; sel = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            check("reset_in_ready", 16'(ir), 16'd1);
            check("reset_out_valid", 16'(ov), 16'd0);
            check("reset_busy", 16'(bz), 16'd0);
            check("reset_product", prod, 16'd0);
        end

        // WIDTH=4 unsigned and signed
        sel = 1'b0;
        send(8'd10, 8'd12, 1'b0);  recv(1'b0, 0);
        send(8'd13, 8'd12, 1'b0);  recv(1'b0, 0);
        send(8'hA,  8'hC,  1'b1);  recv(1'b0, 0);
        send(8'h8,  8'h7,  1'b1);  recv(1'b0, 0);
        send(8'h8,  8'h8,  1'b1);  recv(1'b0, 0);
        send(8'h0,  8'hF,  1'b1);  recv(1'b0, 0);

        // Back-pressure with ignored in_valid pulses during DONE
        send(8'h7, 8'hF, 1'b1);    recv(1'b0, 5);

        // Reset asserted for the second CALC edge
        send(8'd13, 8'd12, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_back());
        check("abort_out_valid", 16'(ov), 16'd0);
        check("abort_busy", 16'(bz), 16'd0);
        check("abort_product", prod, 16'd0);
        check("abort_in_ready", 16'(ir), 16'd1);
        send(8'd10, 8'd12, 1'b0);  recv(1'b0, 0);

        // Input isolation during CALC
        send(8'hB, 8'h5, 1'b1);    recv(1'b1, 0);
        send(8'hE, 8'h9, 1'b0);    recv(1'b1, 1);

        // WIDTH=8
        sel = 1'b1;
        send(8'd22,  8'd11,  1'b0); recv(1'b0, 0);
        send(8'h80,  8'h80,  1'b1); recv(1'b0, 0);
        send(8'd255, 8'd255, 1'b0); recv(1'b0, 0);
        send(8'h80,  8'h7F,  1'b1); recv(1'b1, 2);
        for (int i = 0; i < 6; i++) begin
            send(8'($urandom), 8'($urandom), 1'($urandom));
            recv(1'b1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Parametrised, sequential successor to the team's 4x4 combinational array multiplier. It computes a WIDTH x WIDTH product, unsigned or two's-complement signed, by iterative radix-2 shift-add, one multiplier bit per clock. Operands enter through a valid/ready handshake and the product leaves through a second one, so arithmetic datapaths can use it with back-pressure. It replaces a WIDTH² adder array with one WIDTH-bit adder at the cost of WIDTH cycles of latency.

## Interface
- WIDTH, default 4: operand width in bits (minimum 2); the product is 2*WIDTH bits.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  the block can accept operands.
- inp1  input  WIDTH  multiplicand.
- inp2  input  WIDTH  multiplier.
- is_signed  input  1  1 = two's-complement operands and product; 0 = unsigned.
- out_valid  output  1  `product` holds a completed result.
- out_ready  input  1  the consumer takes the product.
- product  output  2*WIDTH  result; held stable while out_valid=1.
- busy  output  1  high from operand acceptance until the product is taken.

## Operation
- States: IDLE, CALC, DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE. busy=1 in CALC and DONE.
- **IDLE:** a rising edge with in_valid&&in_ready accepts the operands and moves to CALC.
  - The block latches is_signed.
  - It latches |inp1| and |inp2| as WIDTH-bit magnitudes. When is_signed=0, the magnitudes are the raw values.
  - It latches neg = is_signed & (inp1[MSB] ^ inp2[MSB]).
  - It clears the accumulator and sets the bit counter to 0.
- **CALC:** each edge does the following.
  - If the multiplier LSB is 1, add the multiplicand magnitude into the accumulator's upper WIDTH+1 bits.
  - Shift the accumulator/multiplier pair right by 1.
  - Increment the counter.
- **Last CALC edge (counter = WIDTH-1):**
  - Load product with acc_next, or with -acc_next when neg=1.
  - Move to DONE.
- **DONE:** a rising edge with out_ready=1 moves to IDLE. Operands cannot be accepted in that same edge. product keeps its last value after DONE.
- **Arithmetic:**
  - Magnitude of the most-negative operand (1 followed by zeros) is 2^(WIDTH-1), which fits in WIDTH unsigned bits.
  - The product never overflows 2*WIDTH bits in either mode. For example, with WIDTH=4 and is_signed=1, (-8)*(-8)=+64=8'h40.
  - A zero operand gives product 0 with neg ignored. There is no signed negative zero.
- Inputs are ignored outside the IDLE acceptance edge. Changing inp1/inp2/is_signed during CALC has no effect.

## Timing
- Reset (rst=1 at an edge) sets the following, regardless of state:
  - state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, accumulator=0, counter=0.
- Reset mid-CALC or mid-DONE aborts the operation, and the result is lost.
- Latency: operands accepted at edge k give out_valid=1 after edge k+WIDTH. That is WIDTH cycles, independent of operand values, with no early termination.
- Throughput: at most one result per WIDTH+2 cycles. The cycles are accept, WIDTH-1 further CALC edges, at least one DONE cycle, and one IDLE cycle.
- While out_valid=1 and out_ready=0, the block holds product, out_valid, in_ready=0 and busy=1 indefinitely.
- All outputs are registered or decoded only from state. There is no combinational path from inputs to outputs.

## Structure
- Shared package mult_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - a function returning product width 2*WIDTH;
  - a function returning counter width $clog2(WIDTH).
- One sub-module: mult_sign_fix, a combinational helper.
  - Its mode pin selects magnitude extraction (absolute value of a WIDTH-bit signed value) or conditional negation (of a 2*WIDTH-bit value).
  - It is instantiated once per use: inp1 magnitude, inp2 magnitude and result negation.
- Everything else, including the FSM, counter and accumulator, is in the top module.

## Test plan
- **Unsigned, WIDTH=4:**
  - inp1=10, inp2=12, is_signed=0 -> product=8'd120, with out_valid exactly 4 cycles after acceptance.
  - Then inp1=13, inp2=12 -> 8'd156.
- **Signed, WIDTH=4:**
  - 4'b1010 (-6) * 4'b1100 (-4) -> 8'h18.
  - 4'b1000 (-8) * 4'b0111 (7) -> 8'hC8 (-56).
  - 4'b1000 * 4'b1000 -> 8'h40.
- **Width generality, WIDTH=8:**
  - 22*11 unsigned -> 16'h00F2.
  - 8'h80*8'h80 signed -> 16'h4000.
  - 255*255 unsigned -> 16'hFE01.
- **Back-pressure:** hold out_ready=0 for 5 cycles after out_valid -> product, out_valid=1 and in_ready=0 stay stable; in_valid pulses during DONE are ignored; release out_ready -> in_ready=1 on the following cycle.
- **Reset mid-operation:** assert rst at the 2nd CALC edge of 13*12 -> the next cycle shows out_valid=0, busy=0, product=0, in_ready=1; a new 10*12 then completes correctly with product 120.
- **Input isolation:** change inp1/inp2/is_signed every cycle during CALC -> the result matches the operands latched at acceptance.
